// File: rtl/chan_base_dispatch.sv
// chan_base_dispatch
//   Captures the eight per-channel base addresses that arrive on the shared BRAM
//   read bus, strobed by the header reader's one-hot done vector delayed RD_LAT
//   cycles. On start it issues XFER_CNT address commands per channel over a
//   valid/ready handshake.
//
//   Optional feature: define CHAN_MASK_EN to add the chan_mask[7:0] input
//   (1 = channel enabled). The mask is sampled at start. Disabled channels are
//   skipped without an idle cycle. An all-zero mask goes straight to DONE.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   CAPTURE  | waiting for all eight bases to be captured; start ignored
//   ARMED    | all bases held; waiting for start
//   ISSUE    | command in flight (cmd_valid high), walking chan/beat
//   DONE     | one-cycle done pulse, then back to ARMED
module chan_base_dispatch #(
   parameter int          RD_LAT   = 2,
   parameter int          XFER_CNT = 4,
   parameter logic [31:0] STRIDE   = 32'h0000_0040
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  trans_done_onehot,
   input  logic [31:0] ram_rd_data,
   input  logic        start,
`ifdef CHAN_MASK_EN
   input  logic [7:0]  chan_mask,
`endif
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [31:0] cmd_addr,
   output logic [2:0]  cmd_chan,
   output logic [7:0]  base_valid,
   output logic        all_bases_valid,
   output logic        busy,
   output logic        done
);

   localparam int BW = (XFER_CNT > 1) ? $clog2(XFER_CNT) : 1;
   localparam logic [BW-1:0] BEAT_LAST = BW'(XFER_CNT - 1);

   typedef enum logic [1:0] {
      S_CAPTURE = 2'd0,
      S_ARMED   = 2'd1,
      S_ISSUE   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t          state, state_next;
   logic [7:0]      dly [RD_LAT];
   logic [7:0]      strobe;
   logic [31:0]     base [8];
   logic [BW-1:0]   beat_left;
   logic [7:0]      start_mask;
   logic [7:0]      run_mask;
   logic [3:0]      first_hit;
   logic [3:0]      next_hit;
   logic            hs;
   logic            load_first;
   logic            load_next;
   logic            step_beat;
   logic            drop_valid;

   // Lowest set bit of m at or above index from; result is {found, index}.
   function automatic logic [3:0] find_from(input logic [7:0] m, input logic [3:0] from);
      logic [3:0] r;
      r = 4'b0000;
      for (int i = 7; i >= 0; i--) begin
         if (m[i] && (i >= int'(from))) begin
            r = {1'b1, 3'(i)};
         end
      end
      return r;
   endfunction

`ifdef CHAN_MASK_EN
   logic [7:0] mask_q;

   // Hold the enable mask seen at start for the whole dispatch run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_q <= 8'h00;
      end else if ((state == S_ARMED) && start) begin
         mask_q <= chan_mask;
      end
   end

   assign start_mask = chan_mask;
   assign run_mask   = mask_q;
`else
   assign start_mask = 8'hFF;
   assign run_mask   = 8'hFF;
`endif

   assign strobe          = dly[RD_LAT-1];
   assign all_bases_valid = &base_valid;
   assign hs              = cmd_valid && cmd_ready;
   assign first_hit       = find_from(start_mask, 4'd0);
   assign next_hit        = find_from(run_mask, {1'b0, cmd_chan} + 4'd1);

   // Align the one-hot strobes with the BRAM data they select.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < RD_LAT; k++) begin
            dly[k] <= 8'h00;
         end
      end else begin
         dly[0] <= trans_done_onehot;
         for (int k = 1; k < RD_LAT; k++) begin
            dly[k] <= dly[k-1];
         end
      end
   end

   // First strobe per slot wins; later strobes (bit 7 held high) are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_valid <= 8'h00;
         for (int i = 0; i < 8; i++) begin
            base[i] <= 32'h0;
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (strobe[i] && !base_valid[i]) begin
               base[i]       <= ram_rd_data;
               base_valid[i] <= 1'b1;
            end
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_CAPTURE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and datapath control decode.
   always_comb begin
      state_next = state;
      load_first = 1'b0;
      load_next  = 1'b0;
      step_beat  = 1'b0;
      drop_valid = 1'b0;
      case (state)
         S_CAPTURE: begin
            if (all_bases_valid) begin
               state_next = S_ARMED;
            end
         end
         S_ARMED: begin
            if (start) begin
               if (first_hit[3]) begin
                  state_next = S_ISSUE;
                  load_first = 1'b1;
               end else begin
                  state_next = S_DONE;
               end
            end
         end
         S_ISSUE: begin
            if (hs) begin
               if (beat_left != '0) begin
                  step_beat = 1'b1;
               end else if (next_hit[3]) begin
                  load_next = 1'b1;
               end else begin
                  drop_valid = 1'b1;
                  state_next = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_next = S_ARMED;
         end
         default: begin
            state_next = S_CAPTURE;
         end
      endcase
   end

   // Command registers: address advances by STRIDE per beat, beats count down to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_valid <= 1'b0;
         cmd_addr  <= 32'h0;
         cmd_chan  <= 3'd0;
         beat_left <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         if (load_first) begin
            cmd_valid <= 1'b1;
            cmd_chan  <= first_hit[2:0];
            cmd_addr  <= base[first_hit[2:0]];
            beat_left <= BEAT_LAST;
         end else if (load_next) begin
            cmd_chan  <= next_hit[2:0];
            cmd_addr  <= base[next_hit[2:0]];
            beat_left <= BEAT_LAST;
         end else if (step_beat) begin
            cmd_addr  <= cmd_addr + STRIDE;
            beat_left <= beat_left - 1'b1;
         end else if (drop_valid) begin
            cmd_valid <= 1'b0;
         end
         busy <= (state_next == S_ISSUE);
         done <= (state_next == S_DONE);
      end
   end

endmodule

// File: tb/tb_chan_base_dispatch.sv
// tb_chan_base_dispatch
//   Randomized bench with a queue-based reference model of base capture and of
//   the expected command sequence. Define CHAN_MASK_EN to exercise the mask.
module tb_chan_base_dispatch;

   localparam int          RD_LAT   = 2;
   localparam int          XFER_CNT = 4;
   localparam logic [31:0] STRIDE   = 32'h0000_0040;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  trans_done_onehot = 8'h00;
   logic [31:0] ram_rd_data = 32'h0;
   logic        start = 1'b0;
   logic        cmd_ready = 1'b0;
`ifdef CHAN_MASK_EN
   logic [7:0]  chan_mask = 8'hFF;
`endif
   logic        cmd_valid;
   logic [31:0] cmd_addr;
   logic [2:0]  cmd_chan;
   logic [7:0]  base_valid;
   logic        all_bases_valid;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;
   int ready_pct = 100;
   int done_cnt = 0;

   logic [7:0]  oh_q[$];
   logic [31:0] exp_base [8];
   logic [7:0]  exp_bv = 8'h00;
   logic [31:0] got_addr[$];
   logic [2:0]  got_chan[$];

   logic        prev_stall = 1'b0;
   logic [31:0] prev_addr = 32'h0;
   logic [2:0]  prev_chan = 3'd0;

   chan_base_dispatch #(
      .RD_LAT   (RD_LAT),
      .XFER_CNT (XFER_CNT),
      .STRIDE   (STRIDE)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .trans_done_onehot (trans_done_onehot),
      .ram_rd_data       (ram_rd_data),
      .start             (start),
`ifdef CHAN_MASK_EN
      .chan_mask         (chan_mask),
`endif
      .cmd_valid         (cmd_valid),
      .cmd_ready         (cmd_ready),
      .cmd_addr          (cmd_addr),
      .cmd_chan          (cmd_chan),
      .base_valid        (base_valid),
      .all_bases_valid   (all_bases_valid),
      .busy              (busy),
      .done              (done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Observe mid-cycle: handshakes, done pulses, stability under stall.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check_val("stall_valid", 32'(cmd_valid), 32'd1);
            check_val("stall_addr", cmd_addr, prev_addr);
            check_val("stall_chan", 32'(cmd_chan), 32'(prev_chan));
         end
         if (cmd_valid) check_val("busy_in_issue", 32'(busy), 32'd1);
         if (cmd_valid && cmd_ready) begin
            got_addr.push_back(cmd_addr);
            got_chan.push_back(cmd_chan);
         end
         if (done) done_cnt++;
         prev_stall = cmd_valid && !cmd_ready;
         prev_addr  = cmd_addr;
         prev_chan  = cmd_chan;
      end
   end

   // One cycle of stimulus; the model pairs each strobe with data RD_LAT cycles later.
   task automatic step(input logic [7:0] oh, input logic [31:0] d, input logic st);
      logic [7:0] old;
      trans_done_onehot = oh;
      ram_rd_data       = d;
      start             = st;
      cmd_ready         = ($urandom_range(0, 99) < ready_pct);
      oh_q.push_back(oh);
      if (oh_q.size() > RD_LAT) begin
         old = oh_q.pop_front();
         for (int i = 0; i < 8; i++) begin
            if (old[i] && !exp_bv[i]) begin
               exp_base[i] = d;
               exp_bv[i]   = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check_val("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      check_val("rst_base_valid", 32'(base_valid), 32'd0);
      check_val("rst_all_valid", 32'(all_bases_valid), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      repeat (3) step(8'h00, $urandom, 1'b0);
      oh_q.delete();
      exp_bv = 8'h00;
      for (int i = 0; i < 8; i++) exp_base[i] = 32'h0;
      rst_n = 1'b1;
   endtask

   task automatic run_issue(input int pct, input logic [7:0] mask, input logic mid_start, input string tag);
      logic [7:0]  eff;
      logic [31:0] ea[$];
      logic [2:0]  ec[$];
      int n;
`ifdef CHAN_MASK_EN
      chan_mask = mask;
      eff = mask;
`else
      eff = 8'hFF;
      if (mask == 8'h00) eff = 8'hFF;
`endif
      for (int ch = 0; ch < 8; ch++) begin
         if (eff[ch]) begin
            for (int b = 0; b < XFER_CNT; b++) begin
               ea.push_back(exp_base[ch] + 32'(b) * STRIDE);
               ec.push_back(3'(ch));
            end
         end
      end
      got_addr.delete();
      got_chan.delete();
      done_cnt  = 0;
      ready_pct = pct;
      step(8'h00, $urandom, 1'b1);
      n = 0;
      while (done_cnt == 0 && n < 3000) begin
         step(8'h00, $urandom, mid_start && (n == 3));
         n++;
      end
      check_val({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
      repeat (3) step(8'h00, $urandom, 1'b0);
      check_val({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
      check_val({tag, "_cmd_count"}, 32'(got_addr.size()), 32'(ea.size()));
      check_val({tag, "_idle_after"}, 32'(cmd_valid), 32'd0);
      for (int i = 0; i < ea.size() && i < got_addr.size(); i++) begin
         check_val($sformatf("%s_addr%0d", tag, i), got_addr[i], ea[i]);
         check_val($sformatf("%s_chan%0d", tag, i), 32'(got_chan[i]), 32'(ec[i]));
      end
   endtask

   initial begin
      logic [7:0]  pat [6];
      logic [31:0] wrap [4];
      int k;
      pat  = '{8'h03, 8'h08, 8'h04, 8'h10, 8'h60, 8'h80};
      wrap = '{32'hFFFF_FFC0, 32'h0000_0000, 32'h0000_0040, 32'h0000_0080};

      do_reset();

      // start while still capturing must not latch
      step(8'h00, $urandom, 1'b1);
      repeat (4) step(8'h00, $urandom, 1'b0);
      check_val("capture_start_ignored", 32'(cmd_valid), 32'd0);

      // T1: one-hot walk with data RD_LAT cycles behind
      for (int t = 0; t < 8 + RD_LAT + 1; t++) begin
         step((t < 8) ? 8'(1 << t) : 8'h00,
              (t >= RD_LAT) ? 32'h1000 * 32'(t - RD_LAT + 1) : $urandom, 1'b0);
      end
      step(8'h00, $urandom, 1'b0);
      check_val("t1_base_valid", 32'(base_valid), 32'(exp_bv));
      check_val("t1_base_valid_abs", 32'(base_valid), 32'hFF);
      check_val("t1_all_valid", 32'(all_bases_valid), 32'd1);
      check_val("t1_no_cmd", 32'(cmd_valid), 32'd0);

      // T2: bit 7 held high with changing data, plus stray strobes
      for (int t = 0; t < 20; t++) step(8'h80 | 8'($urandom_range(0, 255) & 8'h11), $urandom, 1'b0);
      repeat (RD_LAT + 1) step(8'h00, $urandom, 1'b0);
      check_val("t2_base_valid", 32'(base_valid), 32'hFF);

      // T3: full-rate dispatch
      run_issue(100, 8'hFF, 1'b0, "t3");
      if (got_addr.size() > 0) begin
         check_val("t3_first_abs", got_addr[0], 32'h0000_1000);
         check_val("t3_last_abs", got_addr[got_addr.size()-1], 32'h0000_80C0);
      end else begin
         check_val("t3_no_cmds", 32'(got_addr.size()), 32'd32);
      end

      // T4: random stalls, start re-pulsed mid-dispatch
      run_issue(40, 8'hFF, 1'b1, "t4");

      // T5: fresh capture with slot 3 near the top of the address space
      do_reset();
      for (int t = 0; t < 16 + RD_LAT; t++) begin
         step((t < 6) ? pat[t] : ((t < 16) ? 8'h80 : 8'h00),
              (t == 1 + RD_LAT) ? 32'hFFFF_FFC0 : $urandom, 1'b0);
      end
      step(8'h00, $urandom, 1'b0);
      check_val("t5_base_valid", 32'(base_valid), 32'hFF);
      check_val("t5_base3_model", exp_base[3], 32'hFFFF_FFC0);
      run_issue(60, 8'hFF, 1'b0, "t5");
      k = 0;
      for (int i = 0; i < got_chan.size(); i++) begin
         if (got_chan[i] == 3'd3 && k < 4) begin
            check_val($sformatf("t5_ch3_%0d", k), got_addr[i], wrap[k]);
            k++;
         end
      end
      check_val("t5_ch3_count", 32'(k), 32'd4);

      // T6: reset in the middle of a dispatch
      ready_pct = 50;
      step(8'h00, $urandom, 1'b1);
      repeat (5) step(8'h00, $urandom, 1'b0);
      check_val("t6_pre_valid", 32'(cmd_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check_val("t6_async_valid", 32'(cmd_valid), 32'd0);
      check_val("t6_base_valid", 32'(base_valid), 32'd0);
      do_reset();
      step(8'h00, $urandom, 1'b1);
      repeat (4) step(8'h00, $urandom, 1'b0);
      check_val("t6_capture_state", 32'(cmd_valid | busy), 32'd0);
      for (int t = 0; t < 8 + RD_LAT + 1; t++) begin
         step((t < 8) ? 8'(8'h80 >> t) : 8'h00, $urandom, 1'b0);
      end
      step(8'h00, $urandom, 1'b0);
      check_val("t6_recapture", 32'(base_valid), 32'hFF);
      run_issue(70, 8'hFF, 1'b0, "t6");
`ifdef CHAN_MASK_EN
      run_issue(70, 8'h05, 1'b0, "t6_mask05");
      run_issue(70, 8'h00, 1'b0, "t6_mask00");
      run_issue(50, 8'h81, 1'b0, "t6_mask81");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
